// File: rtl/imem_arb_pkg.sv
// Shared definitions for the instruction-ROM upgrade arbiter.
// Contents:
//   ADDR_W_DEF / DATA_W_DEF / RELEASE_CYC_DEF : default widths and hold length
//   arb_state_e                              : arbiter FSM state encoding
package imem_arb_pkg;
  localparam int ADDR_W_DEF      = 14;
  localparam int DATA_W_DEF      = 32;
  localparam int RELEASE_CYC_DEF = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    UPG     = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;
endpackage

// File: rtl/imem_upg_arbiter_hold_timer.sv
// hold_timer: countdown that measures how long the CPU is kept in reset
// after an upgrade session.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset (reset loads the counter)
//   load      : reload the counter to CYC-1 (has priority over tick)
//   tick      : count down by one this cycle
//   done      : high during the last ticking cycle (CYC-th tick since load)
module hold_timer #(
  parameter int CYC = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic tick,
  output logic done
);
  localparam int W = (CYC > 1) ? $clog2(CYC) : 1;
  localparam logic [W-1:0] TOP = W'(CYC - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= TOP;
    end else if (load) begin
      cnt <= TOP;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = tick && (cnt == '0);
endmodule

// File: rtl/imem_upg_arbiter.sv
// imem_upg_arbiter: arbitrates the instruction ROM between the CPU fetch
// path and a UART upgrader, holding the CPU in reset while the ROM is being
// rewritten and for RELEASE_CYC cycles afterwards.
// Optional feature: define IMEM_ARB_CHECKSUM_EN to add upg_csum, the XOR of
// all words written in the current upgrade session.
// Ports:
//   clk, rstn              : clock, asynchronous active-low reset
//   fetch_req, fetch_addr  : CPU instruction fetch
//   upg_rst_i (low = own), upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i : upgrader
//   rom_addr, rom_din, rom_we : ROM port (combinational from the state)
//   inst_valid             : ROM read data valid (fetch_req delayed one cycle)
//   cpu_rstn               : active-low CPU hold
//   upg_busy               : upgrade (or post-upgrade hold) in progress
//   wr_count               : words written this session, saturating at 2^ADDR_W
//   dbg_state              : current FSM state
//   upg_csum               : session checksum (IMEM_ARB_CHECKSUM_EN only)
// Handshake: fetch_req is a per-cycle request with no back-pressure; the
// ROM answers one cycle later, flagged by inst_valid. A write happens in
// every UPG cycle where upg_wen_i is high.
module imem_upg_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int RELEASE_CYC = RELEASE_CYC_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              upg_rst_i,
  input  logic              upg_wen_i,
  input  logic [ADDR_W-1:0] upg_adr_i,
  input  logic [DATA_W-1:0] upg_dat_i,
  input  logic              upg_done_i,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_din,
  output logic              rom_we,
  output logic              inst_valid,
  output logic              cpu_rstn,
  output logic              upg_busy,
  output arb_state_e        dbg_state,
  output logic [ADDR_W:0]   wr_count
`ifdef IMEM_ARB_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] upg_csum
`endif
);
  localparam logic [ADDR_W:0] WC_MAX = {1'b1, {ADDR_W{1'b0}}};

  arb_state_e state, next_state;
  logic       upg_req;
  logic       hold_done;
  logic       session_start;
  logic       write_now;

  assign upg_req       = !upg_rst_i && !upg_done_i;
  assign session_start = (state == RUN) && (next_state == UPG);
  assign write_now     = (state == UPG) && upg_wen_i;
  assign dbg_state     = state;

  hold_timer #(.CYC(RELEASE_CYC)) u_hold (
    .clk  (clk),
    .rstn (rstn),
    .load (state != RELEASE),
    .tick (state == RELEASE),
    .done (hold_done)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= RELEASE;
    else       state <= next_state;
  end

  // A fresh upgrade request during the hold wins over the hold expiring.
  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (upg_req) next_state = UPG;
      UPG:     if (upg_done_i || upg_rst_i) next_state = RELEASE;
      RELEASE: begin
        if (upg_req)        next_state = UPG;
        else if (hold_done) next_state = RUN;
      end
      default: next_state = RELEASE;
    endcase
  end

  always_comb begin
    rom_addr = fetch_addr;
    rom_din  = '0;
    rom_we   = 1'b0;
    if (state == UPG) begin
      rom_addr = upg_adr_i;
      rom_din  = upg_dat_i;
      rom_we   = upg_wen_i;
    end
  end

  // Outputs are registered from next_state so they line up with the state
  // they describe. inst_valid is dropped on the edge leaving RUN.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cpu_rstn   <= 1'b0;
      upg_busy   <= 1'b1;
      inst_valid <= 1'b0;
      wr_count   <= '0;
    end else begin
      cpu_rstn   <= (next_state == RUN);
      upg_busy   <= (next_state != RUN);
      inst_valid <= (state == RUN) && (next_state == RUN) && fetch_req;
      if (session_start)
        wr_count <= '0;
      else if (write_now && (wr_count != WC_MAX))
        wr_count <= wr_count + 1'b1;
    end
  end

`ifdef IMEM_ARB_CHECKSUM_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              upg_csum <= '0;
    else if (session_start) upg_csum <= '0;
    else if (write_now)     upg_csum <= upg_csum ^ upg_dat_i;
  end
`endif
endmodule

// File: tb/tb_imem_upg_arbiter.sv
// Testbench for imem_upg_arbiter: directed scenarios followed by random
// traffic, checked against a cycle-level behavioural model of the arbiter.
// Expected per-cycle status and expected ROM writes are queued by the
// driver; a negedge monitor pops and compares them.
module tb_imem_upg_arbiter;
  import imem_arb_pkg::*;

  localparam int AW     = 4;
  localparam int DW     = 32;
  localparam int RC     = 4;
  localparam int WC_SAT = 1 << AW;

  localparam int M_RUN = 0;
  localparam int M_UPG = 1;
  localparam int M_REL = 2;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          upg_rst_i = 1'b1;
  logic          upg_wen_i = 1'b0;
  logic [AW-1:0] upg_adr_i = '0;
  logic [DW-1:0] upg_dat_i = '0;
  logic          upg_done_i = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_din;
  logic          rom_we;
  logic          inst_valid;
  logic          cpu_rstn;
  logic          upg_busy;
  arb_state_e    dbg_state;
  logic [AW:0]   wr_count;
`ifdef IMEM_ARB_CHECKSUM_EN
  logic [DW-1:0] upg_csum;
`endif

  always #5 clk = ~clk;

  imem_upg_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RELEASE_CYC(RC)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .upg_rst_i  (upg_rst_i),
    .upg_wen_i  (upg_wen_i),
    .upg_adr_i  (upg_adr_i),
    .upg_dat_i  (upg_dat_i),
    .upg_done_i (upg_done_i),
    .rom_addr   (rom_addr),
    .rom_din    (rom_din),
    .rom_we     (rom_we),
    .inst_valid (inst_valid),
    .cpu_rstn   (cpu_rstn),
    .upg_busy   (upg_busy),
    .dbg_state  (dbg_state),
    .wr_count   (wr_count)
`ifdef IMEM_ARB_CHECKSUM_EN
    ,
    .upg_csum   (upg_csum)
`endif
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [1:0]    st;
    logic          cpu_rstn;
    logic          busy;
    logic          iv;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [AW:0]   wc;
    logic [DW-1:0] csum;
  } status_t;

  status_t             exp_q[$];
  logic [AW+DW-1:0]    wr_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc_no  = 0;

  // ---------------- reference model ----------------
  int            m_mode;
  int            m_hold;   // RELEASE cycles still to spend
  int            m_words;
  logic          m_iv;
  logic [DW-1:0] m_csum;

  task automatic model_reset();
    m_mode  = M_REL;
    m_hold  = RC;
    m_words = 0;
    m_iv    = 1'b0;
    m_csum  = '0;
  endtask

  // Advance one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit want;
    want = !upg_rst_i && !upg_done_i;
    m_iv = 1'b0;
    case (m_mode)
      M_RUN: begin
        if (want) begin
          m_mode  = M_UPG;
          m_words = 0;
          m_csum  = '0;
        end else begin
          m_iv = fetch_req;
        end
      end
      M_UPG: begin
        if (upg_wen_i) begin
          if (m_words < WC_SAT) m_words = m_words + 1;
          m_csum = m_csum ^ upg_dat_i;
        end
        if (upg_done_i || upg_rst_i) begin
          m_mode = M_REL;
          m_hold = RC;
        end
      end
      default: begin
        if (want) begin
          m_mode = M_UPG;
        end else begin
          m_hold = m_hold - 1;
          if (m_hold == 0) m_mode = M_RUN;
        end
      end
    endcase
  endtask

  task automatic push_expect();
    status_t e;
    e.st       = (m_mode == M_RUN) ? RUN : (m_mode == M_UPG) ? UPG : RELEASE;
    e.cpu_rstn = (m_mode == M_RUN);
    e.busy     = (m_mode != M_RUN);
    e.iv       = m_iv;
    e.we       = (m_mode == M_UPG) && upg_wen_i;
    e.addr     = (m_mode == M_UPG) ? upg_adr_i : fetch_addr;
    e.din      = (m_mode == M_UPG) ? upg_dat_i : '0;
    e.wc       = (AW+1)'(m_words);
`ifdef IMEM_ARB_CHECKSUM_EN
    e.csum     = m_csum;
`else
    e.csum     = '0;
`endif
    exp_q.push_back(e);
    if (e.we) wr_q.push_back({upg_adr_i, upg_dat_i});
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input logic rn, input logic fr, input logic [AW-1:0] fa,
                     input logic ur, input logic wen, input logic [AW-1:0] ua,
                     input logic [DW-1:0] ud, input logic dn);
    @(posedge clk);
    if (!rstn) model_reset();
    else       model_step();
    #1;
    rstn       = rn;
    fetch_req  = fr;
    fetch_addr = fa;
    upg_rst_i  = ur;
    upg_wen_i  = wen;
    upg_adr_i  = ua;
    upg_dat_i  = ud;
    upg_done_i = dn;
    if (!rstn) model_reset();
    cyc_no++;
    push_expect();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic request();
    cyc(1'b1, 1'b1, 4'd7, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic dn);
    cyc(1'b1, 1'b1, 4'd9, 1'b0, 1'b1, a, d, dn);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    status_t a, e;
    logic [AW+DW-1:0] w;
    if (exp_q.size() > 0) begin
      a.st       = dbg_state;
      a.cpu_rstn = cpu_rstn;
      a.busy     = upg_busy;
      a.iv       = inst_valid;
      a.we       = rom_we;
      a.addr     = rom_addr;
      a.din      = rom_din;
      a.wc       = wr_count;
`ifdef IMEM_ARB_CHECKSUM_EN
      a.csum     = upg_csum;
`else
      a.csum     = '0;
`endif
      e = exp_q.pop_front();
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL status cyc=%0d got st=%0d crst=%b busy=%b iv=%b we=%b addr=%h din=%h wc=%0d cs=%h exp st=%0d crst=%b busy=%b iv=%b we=%b addr=%h din=%h wc=%0d cs=%h",
                 cyc_no, a.st, a.cpu_rstn, a.busy, a.iv, a.we, a.addr, a.din, a.wc, a.csum,
                 e.st, e.cpu_rstn, e.busy, e.iv, e.we, e.addr, e.din, e.wc, e.csum);
      end
    end
    if (rom_we === 1'b1) begin
      n_tests++;
      if (wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL rom_write cyc=%0d got addr=%h data=%h exp no write", cyc_no, rom_addr, rom_din);
      end else begin
        w = wr_q.pop_front();
        if ({rom_addr, rom_din} !== w) begin
          n_fail++;
          $display("FAIL rom_write cyc=%0d got addr=%h data=%h exp addr=%h data=%h",
                   cyc_no, rom_addr, rom_din, w[AW+DW-1:DW], w[DW-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    // Reset held with a fetch pending, then released: CPU freed after RC cycles.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'd5, 1'b1, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 4'd5, 1'b1, 1'b0, '0, '0, 1'b0);

    // Three writes in one session.
    request();
    wr(4'd0, 32'hA, 1'b0);
    wr(4'd1, 32'hB, 1'b0);
    wr(4'd2, 32'hC, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    idle(6);

    // Last write coincides with done; checksum of 1 and 3.
    request();
    wr(4'd3, 32'h1, 1'b0);
    wr(4'd4, 32'h3, 1'b1);
    idle(6);

    // Upgrade re-requested in the 2nd RELEASE cycle.
    request();
    wr(4'd5, 32'h55, 1'b1);
    idle(1);
    request();
    wr(4'd6, 32'h66, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0);
    idle(6);

    // Reset pulsed mid-session with a write strobed.
    request();
    wr(4'd7, 32'h77, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 4'd8, 32'h88, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0);
    idle(6);

    // Write count saturation.
    request();
    for (int i = 0; i < WC_SAT + 4; i++) wr(AW'(i), $urandom, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    idle(6);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
          ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
          AW'($urandom),
          ($urandom_range(0, 99) < 20) ? 1'b0 : 1'b1,
          ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0,
          AW'($urandom),
          $urandom,
          ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0);
    end
    idle(8);

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0 || wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got status_left=%0d writes_left=%0d exp 0 and 0", exp_q.size(), wr_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
